ysyx_25060166_lsu: RTL
======================

Name: ysyx_25060166_lsu

Overview:
Load/store unit sitting directly downstream of the RV32E ALU. It takes the ALU's computed memory address and store data plus the access size, and runs one transaction on the core's data-memory request/response bus. It returns lane-aligned read data to the ALU's mem_rdata input. The single-cycle core stalls until resp_valid.

Parameters:
WIDTH, 32, data/address width (fixed 32 for RV32E)
TIMEOUT_CYCLES, 255, WAIT-state cycle limit before error; used only with the optional feature

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  core requests an access
req_ready  out  1  LSU accepts a request (high only in IDLE)
req_wen  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_addr  in  WIDTH  byte address from ALU mem_addr
req_wdata  in  WIDTH  store data, right-justified (byte/half in low bits)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  WIDTH  load data shifted to bit 0, zero above size
resp_err  out  1  misaligned/illegal/bus error, qualified by resp_valid
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_req_wen  out  1  bus write enable
mem_req_addr  out  WIDTH  word-aligned address (req_addr & 32'hFFFF_FFFC)
mem_req_wdata  out  WIDTH  lane-replicated store data
mem_req_wstrb  out  4  byte strobes (0 for loads)
mem_resp_valid  in  1  bus response
mem_resp_rdata  in  WIDTH  raw 32-bit word
mem_resp_err  in  1  bus error, qualified by mem_resp_valid

Behaviour:
- Reset: state = IDLE. All outputs 0, including req_ready while rst_n is low. Reset mid-transaction aborts it; no response is produced.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, latch wen, size, addr[1:0] and data.
  - If size is 3, or a half access has addr[0] = 1, or a word access has addr[1:0] != 0: go to RESP with err = 1. No bus access.
  - Otherwise go to REQ.
- REQ: mem_req_valid = 1. addr, wen, wdata and wstrb are registered and held stable until mem_req_ready. On mem_req_ready, go to WAIT.
- WAIT: on mem_resp_valid, latch the data and mem_resp_err, then go to RESP.
- Any mem_resp_valid outside WAIT is ignored.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. resp_rdata and resp_err are held until the next RESP.
- Strobes (a = addr[1:0]): byte = 4'b0001 << a; half = 4'b0011 << a; word = 4'hF.
- Store data replication: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load data: shifted = mem_resp_rdata >> (8*a), then masked to 8/16/32 bits. Stores return rdata = 0.
- Latency (minimum): request accepted at edge T; mem_req_valid high T..T+1; ready at edge T+1 moves to WAIT; response at edge T+2 moves to RESP; resp_valid during cycle T+3.
- Misaligned latency: resp_valid during cycle T+1.
- Back-to-back: a new request is accepted only in the IDLE cycle following RESP.

Optional Feature:
YSYX_25060166_LSU_TIMEOUT_EN:
- With the macro: an 8-bit counter clears on WAIT entry and increments each WAIT cycle.
- When it reaches TIMEOUT_CYCLES without mem_resp_valid, go to RESP with resp_err = 1 and rdata = 0. A later stray response is ignored.
- Without the macro: WAIT lasts indefinitely and no counter is present.

Decomposition:
- Shared package/header (RV32E.vh): size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings, WSTRB constants.
- One sub-module, ysyx_25060166_lsu_lane: combinational strobe/replicate/extract logic from (size, addr[1:0]). Instantiated once; the FSM stays in the top.

Test Plan:
- SW addr 0x8000_0004, wdata 0xDEAD_BEEF, ready and resp immediate -> bus addr 0x8000_0004, wstrb 4'hF, wdata 0xDEADBEEF; resp_valid in cycle T+3, err = 0.
- SB addr 0x8000_0003, wdata 0x0000_00A5 -> wstrb 4'b1000, wdata 0xA5A5_A5A5, bus addr 0x8000_0000.
- LH addr 0x8000_0002, mem_resp_rdata 0x8123_4567 -> resp_rdata 0x0000_8123. LBU addr 0x...1 with the same rdata -> 0x0000_0045.
- LW addr 0x8000_0002 -> resp_err = 1 at T+1, mem_req_valid never asserted. Size 3 behaves the same way.
- mem_req_ready held low for 5 cycles -> addr/wdata/wstrb stable throughout. mem_resp_err = 1 -> resp_err = 1.
- rst_n pulsed low during WAIT -> all outputs 0 immediately. After release the state is IDLE and the late mem_resp_valid produces no resp_valid. With TIMEOUT_EN and no response, resp_err = 1 after 255 WAIT cycles.

Source files
------------

// File: rtl/ysyx_25060166_lsu_pkg.sv
// Shared encodings for the LSU: access sizes, strobe patterns, FSM states
// and the alignment rule used to reject an access before it reaches the bus.
package ysyx_25060166_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_B    = 4'b0001;
  localparam logic [3:0] WSTRB_H    = 4'b0011;
  localparam logic [3:0] WSTRB_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_ILL) || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/ysyx_25060166_lsu_lane.sv
// Byte-lane steering: store strobes and data replication, plus load
// extraction (shift to bit 0 and zero above the access size).
module ysyx_25060166_lsu_lane
  import ysyx_25060166_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    wstrb     = WSTRB_NONE;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (size)
      SZ_BYTE: begin
        wstrb     = WSTRB_B << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, shifted[7:0]};
      end
      SZ_HALF: begin
        wstrb     = WSTRB_H << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0, shifted[15:0]};
      end
      SZ_WORD: wstrb = WSTRB_W;
      default: ;
    endcase
  end

endmodule

// File: rtl/ysyx_25060166_lsu.sv
// RV32E load/store unit: one bus transaction per request, IDLE/REQ/WAIT/RESP.
// Optional WAIT timeout enabled by YSYX_25060166_LSU_TIMEOUT_EN.
module ysyx_25060166_lsu
  import ysyx_25060166_lsu_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_wen,
  input  logic [1:0]       req_size,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_req_wen,
  output logic [WIDTH-1:0] mem_req_addr,
  output logic [WIDTH-1:0] mem_req_wdata,
  output logic [3:0]       mem_req_wstrb,
  input  logic             mem_resp_valid,
  input  logic [WIDTH-1:0] mem_resp_rdata,
  input  logic             mem_resp_err
);

  state_e           state_q, state_d;
  logic             wen_q, wen_d;
  logic [1:0]       size_q, size_d;
  logic [1:0]       off_q, off_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
`ifdef YSYX_25060166_LSU_TIMEOUT_EN
  logic [7:0]       cnt_q, cnt_d;
`endif

  logic [1:0]       lane_size, lane_off;
  logic [3:0]       lane_wstrb;
  logic [WIDTH-1:0] lane_wdata, lane_rdata;

  // One lane instance serves both directions: request fields while IDLE,
  // the latched size/offset once the transaction is in flight.
  ysyx_25060166_lsu_lane u_lane (
    .size      (lane_size),
    .off       (lane_off),
    .wdata     (req_wdata),
    .rdata     (mem_resp_rdata),
    .wstrb     (lane_wstrb),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  always_comb begin
    state_d   = state_q;
    wen_d     = wen_q;
    size_d    = size_q;
    off_d     = off_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    lane_size = size_q;
    lane_off  = off_q;
`ifdef YSYX_25060166_LSU_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        lane_size = req_size;
        lane_off  = req_addr[1:0];
        if (req_valid) begin
          wen_d   = req_wen;
          size_d  = req_size;
          off_d   = req_addr[1:0];
          addr_d  = {req_addr[WIDTH-1:2], 2'b00};
          wdata_d = lane_wdata;
          wstrb_d = req_wen ? lane_wstrb : WSTRB_NONE;
          if (misaligned(req_size, req_addr[1:0])) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
`ifdef YSYX_25060166_LSU_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d = ST_RESP;
          err_d   = mem_resp_err;
          rdata_d = wen_q ? '0 : lane_rdata;
        end
`ifdef YSYX_25060166_LSU_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wen_q   <= 1'b0;
      size_q  <= SZ_BYTE;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= WSTRB_NONE;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef YSYX_25060166_LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      size_q  <= size_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef YSYX_25060166_LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // State resets to IDLE, so req_ready is gated to stay low while in reset.
  assign req_ready     = (state_q == ST_IDLE) && rst_n;
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_wen   = wen_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wstrb = wstrb_q;

endmodule
